// File: rtl/glb_write_pkg.sv
// Shared types and constants for the glb_write block stream writer.
package glb_write_pkg;

   localparam int DEFAULT_DEPTH = 2048;
   localparam int STREAM_W      = 17;
   localparam int GAP_CYCLES    = 3;
   localparam int GAP_CNT_W     = $clog2(GAP_CYCLES + 1);

   typedef enum logic [2:0] {
      IDLE,
      ARMED,
      GAP,
      HDR0,
      PLD0,
      HDR1,
      PLD1,
      DONE
   } state_e;

   // Limits a requested payload length to the number of words a bank holds.
   function automatic int unsigned clamp_size(input int unsigned size,
                                              input int unsigned depth);
      return (size > depth) ? depth : size;
   endfunction

endpackage

// File: rtl/glb_write_if.sv
// Valid/ready stream carrying header and payload words, plus the sticky done flag.
interface glb_write_if;
   import glb_write_pkg::*;

   logic [STREAM_W-1:0] data;
   logic                valid;
   logic                ready;
   logic                done;

   modport master (output data, output valid, output done, input ready);
   modport slave  (input data, input valid, input done, output ready);

endinterface

// File: rtl/glb_write_bank.sv
// One 16-bit 1R1W bank with a registered read port; the read register
// doubles as the prefetch stage that hides the read latency from the stream.
module glb_write_bank
   import glb_write_pkg::*;
#(
   parameter int DEPTH  = DEFAULT_DEPTH,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [15:0]       wr_data,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [15:0]       rd_data
);

   logic [15:0] mem_q [DEPTH];
   logic [15:0] rd_data_q;
   logic [15:0] rd_data_d;

   // Storage array; never reset so contents survive a mid-transfer reset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

   // Read register only moves when a new word is requested, so it holds under backpressure.
   always_comb begin
      rd_data_d = rd_data_q;
      if (rd_en) begin
         rd_data_d = mem_q[rd_addr];
      end
   end

   // Read register update with synchronous clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_data_q <= '0;
      end else begin
         rd_data_q <= rd_data_d;
      end
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/glb_write.sv
// Streams one or two bank-backed blocks (header word then payload words)
// after a flush strobe. Optional feature macro: GLB_WRITE_STALL_CNT_EN adds
// a saturating stall_cnt output counting valid && !ready cycles.
module glb_write
   import glb_write_pkg::*;
#(
   parameter int DEPTH  = DEFAULT_DEPTH,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              cfg_num_blocks,
   input  logic [ADDR_W:0]   cfg_size_0,
   input  logic [ADDR_W:0]   cfg_size_1,
   input  logic              mem_wr_en,
   input  logic              mem_wr_bank,
   input  logic [ADDR_W-1:0] mem_wr_addr,
   input  logic [15:0]       mem_wr_data,
`ifdef GLB_WRITE_STALL_CNT_EN
   output logic [31:0]       stall_cnt,
`endif
   glb_write_if.master       strm
);

   localparam int SIZE_W = ADDR_W + 1;

   state_e               state_q, state_d;
   logic [SIZE_W-1:0]    size0_q, size0_d;
   logic [SIZE_W-1:0]    size1_q, size1_d;
   logic                 num_blocks_q, num_blocks_d;
   logic [GAP_CNT_W-1:0] gap_cnt_q, gap_cnt_d;
   logic [ADDR_W-1:0]    idx_q, idx_d;
   logic [ADDR_W-1:0]    rd_addr;
   logic                 rd_en0, rd_en1;
   logic                 wr_en0, wr_en1;
   logic                 fill_ok;
   logic                 xfer;
   logic                 last0, last1;
   logic [15:0]          rd_data0, rd_data1;

   assign xfer    = strm.valid && strm.ready;
   assign last0   = (({1'b0, idx_q} + SIZE_W'(1)) == size0_q);
   assign last1   = (({1'b0, idx_q} + SIZE_W'(1)) == size1_q);
   assign fill_ok = (state_q == IDLE) || (state_q == ARMED) || (state_q == DONE);
   assign wr_en0  = mem_wr_en && fill_ok && !mem_wr_bank;
   assign wr_en1  = mem_wr_en && fill_ok &&  mem_wr_bank;

   glb_write_bank #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_bank0 (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en0),
      .wr_addr (mem_wr_addr),
      .wr_data (mem_wr_data),
      .rd_en   (rd_en0),
      .rd_addr (rd_addr),
      .rd_data (rd_data0)
   );

   glb_write_bank #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_bank1 (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en1),
      .wr_addr (mem_wr_addr),
      .wr_data (mem_wr_data),
      .rd_en   (rd_en1),
      .rd_addr (rd_addr),
      .rd_data (rd_data1)
   );

   // Next-state logic; each accepted word issues the read for the following payload word.
   always_comb begin
      state_d      = state_q;
      size0_d      = size0_q;
      size1_d      = size1_q;
      num_blocks_d = num_blocks_q;
      gap_cnt_d    = gap_cnt_q;
      idx_d        = idx_q;
      rd_en0       = 1'b0;
      rd_en1       = 1'b0;
      rd_addr      = '0;
      unique case (state_q)
         IDLE: begin
            if (flush) state_d = ARMED;
         end
         ARMED: begin
            if (!flush) begin
               state_d      = GAP;
               gap_cnt_d    = '0;
               num_blocks_d = cfg_num_blocks;
               size0_d      = SIZE_W'(clamp_size(32'(cfg_size_0), DEPTH));
               size1_d      = SIZE_W'(clamp_size(32'(cfg_size_1), DEPTH));
            end
         end
         GAP: begin
            if (flush) state_d = ARMED;
            else if (gap_cnt_q == GAP_CNT_W'(GAP_CYCLES - 1)) state_d = HDR0;
            else gap_cnt_d = gap_cnt_q + GAP_CNT_W'(1);
         end
         HDR0: begin
            if (flush) state_d = ARMED;
            else if (xfer) begin
               idx_d = '0;
               if (size0_q != '0) begin
                  state_d = PLD0;
                  rd_en0  = 1'b1;
               end else if (num_blocks_q) begin
                  state_d = HDR1;
               end else begin
                  state_d = DONE;
               end
            end
         end
         PLD0: begin
            if (flush) state_d = ARMED;
            else if (xfer) begin
               if (last0) begin
                  state_d = num_blocks_q ? HDR1 : DONE;
               end else begin
                  idx_d   = idx_q + ADDR_W'(1);
                  rd_en0  = 1'b1;
                  rd_addr = idx_q + ADDR_W'(1);
               end
            end
         end
         HDR1: begin
            if (flush) state_d = ARMED;
            else if (xfer) begin
               idx_d = '0;
               if (size1_q != '0) begin
                  state_d = PLD1;
                  rd_en1  = 1'b1;
               end else begin
                  state_d = DONE;
               end
            end
         end
         PLD1: begin
            if (flush) state_d = ARMED;
            else if (xfer) begin
               if (last1) begin
                  state_d = DONE;
               end else begin
                  idx_d   = idx_q + ADDR_W'(1);
                  rd_en1  = 1'b1;
                  rd_addr = idx_q + ADDR_W'(1);
               end
            end
         end
         DONE: begin
            if (flush) state_d = ARMED;
         end
      endcase
   end

   // Stream outputs decoded from registered state, so they stay stable while stalled.
   always_comb begin
      strm.valid = 1'b0;
      strm.data  = '0;
      strm.done  = 1'b0;
      case (state_q)
         HDR0: begin
            strm.valid = 1'b1;
            strm.data  = STREAM_W'(size0_q);
         end
         PLD0: begin
            strm.valid = 1'b1;
            strm.data  = {1'b0, rd_data0};
         end
         HDR1: begin
            strm.valid = 1'b1;
            strm.data  = STREAM_W'(size1_q);
         end
         PLD1: begin
            strm.valid = 1'b1;
            strm.data  = {1'b0, rd_data1};
         end
         DONE: strm.done = 1'b1;
         default: ;
      endcase
   end

   // Control registers with synchronous clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         size0_q      <= '0;
         size1_q      <= '0;
         num_blocks_q <= 1'b0;
         gap_cnt_q    <= '0;
         idx_q        <= '0;
      end else begin
         state_q      <= state_d;
         size0_q      <= size0_d;
         size1_q      <= size1_d;
         num_blocks_q <= num_blocks_d;
         gap_cnt_q    <= gap_cnt_d;
         idx_q        <= idx_d;
      end
   end

`ifdef GLB_WRITE_STALL_CNT_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;

   // Stall counter restarts with each stream and saturates instead of wrapping.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if ((state_q == ARMED) && !flush) begin
         stall_cnt_d = '0;
      end else if (strm.valid && !strm.ready && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end
   end

   // Stall counter register.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_glb_write.sv
// Directed, scoreboard-based bench for glb_write. Expected words are queued
// from a local bank model when a stream is armed and popped on each transfer.
module tb_glb_write;
   import glb_write_pkg::*;

   localparam int DEPTH  = DEFAULT_DEPTH;
   localparam int ADDR_W = $clog2(DEPTH);
   localparam int SIZE_W = ADDR_W + 1;

   logic              clk;
   logic              rst;
   logic              flush;
   logic              cfg_num_blocks;
   logic [SIZE_W-1:0] cfg_size_0;
   logic [SIZE_W-1:0] cfg_size_1;
   logic              mem_wr_en;
   logic              mem_wr_bank;
   logic [ADDR_W-1:0] mem_wr_addr;
   logic [15:0]       mem_wr_data;
`ifdef GLB_WRITE_STALL_CNT_EN
   logic [31:0]       stall_cnt;
`endif

   glb_write_if sif ();

   glb_write #(.DEPTH(DEPTH)) dut (
      .clk            (clk),
      .rst            (rst),
      .flush          (flush),
      .cfg_num_blocks (cfg_num_blocks),
      .cfg_size_0     (cfg_size_0),
      .cfg_size_1     (cfg_size_1),
      .mem_wr_en      (mem_wr_en),
      .mem_wr_bank    (mem_wr_bank),
      .mem_wr_addr    (mem_wr_addr),
      .mem_wr_data    (mem_wr_data),
`ifdef GLB_WRITE_STALL_CNT_EN
      .stall_cnt      (stall_cnt),
`endif
      .strm           (sif)
   );

   int          tests_run    = 0;
   int          tests_failed = 0;
   int          tb_stall     = 0;
   logic [16:0] exp_q [$];
   logic [15:0] bank0_m [DEPTH];
   logic [15:0] bank1_m [DEPTH];

   // Free-running clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard time limit so a stuck design still ends the run.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] time limit reached");
   end

   function automatic int clampSize(input int s);
      return (s > DEPTH) ? DEPTH : s;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      tests_run++;
      assert (observed === expected) else begin
         tests_failed++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic fillWord(input logic bank, input int addr, input logic [15:0] value);
      mem_wr_en   = 1'b1;
      mem_wr_bank = bank;
      mem_wr_addr = ADDR_W'(addr);
      mem_wr_data = value;
      if (bank) bank1_m[addr] = value;
      else      bank0_m[addr] = value;
      tick();
      mem_wr_en = 1'b0;
   endtask

   // Queue the expected stream, pulse flush, and check the three-cycle gap.
   task automatic applyStimulus(input logic nblk, input int s0, input int s1, input string tag);
      int c0;
      int c1;
      c0 = clampSize(s0);
      c1 = clampSize(s1);
      exp_q.push_back(17'(c0));
      for (int i = 0; i < c0; i++) exp_q.push_back({1'b0, bank0_m[i]});
      if (nblk) begin
         exp_q.push_back(17'(c1));
         for (int i = 0; i < c1; i++) exp_q.push_back({1'b0, bank1_m[i]});
      end
      cfg_num_blocks = nblk;
      cfg_size_0     = SIZE_W'(s0);
      cfg_size_1     = SIZE_W'(s1);
      sif.ready      = 1'b1;
      tb_stall       = 0;
      flush          = 1'b1;
      tick();
      checkOutput({tag, " armed done"}, 32'(sif.done), 32'd0);
      flush = 1'b0;
      for (int k = 0; k < GAP_CYCLES; k++) begin
         tick();
         checkOutput({tag, " gap valid"}, 32'(sif.valid), 32'd0);
      end
      tick();
      checkOutput({tag, " first valid"}, 32'(sif.valid), 32'd1);
   endtask

   // One clock: score a transfer if one happens, then check hold-on-stall.
   task automatic stepCycle(input string tag);
      logic [16:0] held;
      logic [16:0] exp_word;
      logic        stalled;
      if (sif.valid && sif.ready && (exp_q.size() != 0)) begin
         exp_word = exp_q.pop_front();
         checkOutput({tag, " word"}, 32'(sif.data), 32'(exp_word));
      end
      stalled = sif.valid && !sif.ready;
      held    = sif.data;
      if (stalled) tb_stall++;
      tick();
      if (stalled) begin
         checkOutput({tag, " hold valid"}, 32'(sif.valid), 32'd1);
         checkOutput({tag, " hold data"}, 32'(sif.data), 32'(held));
      end
   endtask

   task automatic runStream(input logic rand_ready, input string tag);
      int cycles;
      int words;
      cycles = 0;
      words  = exp_q.size();
      while ((exp_q.size() != 0) && (cycles < 6000)) begin
         sif.ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         stepCycle(tag);
         cycles++;
      end
      sif.ready = 1'b1;
      checkOutput({tag, " drained"}, 32'(exp_q.size()), 32'd0);
      if (!rand_ready) checkOutput({tag, " cycles"}, 32'(cycles), 32'(words));
      checkOutput({tag, " done"}, 32'(sif.done), 32'd1);
      checkOutput({tag, " valid after"}, 32'(sif.valid), 32'd0);
   endtask

   // Directed sequence.
   initial begin
      rst            = 1'b1;
      flush          = 1'b0;
      cfg_num_blocks = 1'b0;
      cfg_size_0     = '0;
      cfg_size_1     = '0;
      mem_wr_en      = 1'b0;
      mem_wr_bank    = 1'b0;
      mem_wr_addr    = '0;
      mem_wr_data    = '0;
      sif.ready      = 1'b1;
      @(negedge clk);
      tick();
      tick();
      checkOutput("reset valid", 32'(sif.valid), 32'd0);
      checkOutput("reset data", 32'(sif.data), 32'd0);
      checkOutput("reset done", 32'(sif.done), 32'd0);
      checkOutput("reset state", 32'(dut.state_q), 32'(IDLE));
      rst = 1'b0;

      for (int i = 0; i < DEPTH; i++) fillWord(1'b0, i, 16'(i));
      fillWord(1'b1, 0, 16'hBEEF);
      fillWord(1'b1, 1, 16'hCAFE);

      $display("[TB] one block");
      applyStimulus(1'b0, 5, 0, "one");
      runStream(1'b0, "one");

      $display("[TB] two blocks");
      applyStimulus(1'b1, 3, 2, "two");
      runStream(1'b0, "two");

      $display("[TB] backpressure");
      applyStimulus(1'b0, 5, 0, "bp");
      runStream(1'b1, "bp");
`ifdef GLB_WRITE_STALL_CNT_EN
      checkOutput("bp stall_cnt", stall_cnt, 32'(tb_stall));
`endif

      $display("[TB] zero size");
      applyStimulus(1'b1, 0, 1, "zero");
      runStream(1'b0, "zero");

      $display("[TB] abort");
      applyStimulus(1'b0, 5, 0, "abort");
      for (int k = 0; k < 3; k++) stepCycle("abort");
      checkOutput("abort word2", 32'(sif.data), 32'h2);
      flush = 1'b1;
      exp_q.delete();
      tick();
      checkOutput("abort valid", 32'(sif.valid), 32'd0);
      applyStimulus(1'b0, 5, 0, "restart");
      runStream(1'b0, "restart");

      $display("[TB] reset mid-stream");
      applyStimulus(1'b1, 3, 2, "rst");
      for (int k = 0; k < 5; k++) stepCycle("rst");
      checkOutput("rst pld1 valid", 32'(sif.valid), 32'd1);
      rst = 1'b1;
      exp_q.delete();
      tick();
      checkOutput("rst valid", 32'(sif.valid), 32'd0);
      checkOutput("rst done", 32'(sif.done), 32'd0);
      checkOutput("rst state", 32'(dut.state_q), 32'(IDLE));
      rst = 1'b0;
      applyStimulus(1'b1, 3, 2, "retained");
      runStream(1'b0, "retained");

      $display("[TB] clamp");
      applyStimulus(1'b0, 4095, 0, "clamp");
      checkOutput("clamp header", 32'(sif.data), 32'h800);
      runStream(1'b0, "clamp");

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/glb_write.md
GLB_WRITE -- requirements
Module: glb_write

Interface
REQ-001 SHALL have parameter DEPTH, default 2048, words per bank; ADDR_W = $clog2(DEPTH).
REQ-002 SHALL have port clk  input  1  sole clock; all logic on posedge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port flush  input  1  arm/abort strobe.
REQ-005 SHALL have port cfg_num_blocks  input  1  0 = one block, 1 = two blocks; sampled at flush fall.
REQ-006 SHALL have ports cfg_size_0, cfg_size_1  input  ADDR_W+1  payload word counts; sampled at flush fall.
REQ-007 SHALL have ports mem_wr_en (1), mem_wr_bank (1), mem_wr_addr (ADDR_W), mem_wr_data (16), all inputs, forming the bank fill port.
REQ-008 SHALL have port data  output  17  stream word.
REQ-009 SHALL have port valid  output  1  data is valid.
REQ-010 SHALL have port ready  input  1  sink accepts.
REQ-011 SHALL have port done  output  1  all blocks sent.

Function
REQ-012 SHALL use FSM states IDLE, ARMED, GAP, HDR0, PLD0, HDR1, PLD1, DONE.
REQ-013 SHALL go IDLE->ARMED when flush is sampled 1, and ARMED->GAP when flush is next sampled 0, latching cfg_* in that cycle.
REQ-014 SHALL hold GAP for 3 cycles, so valid first asserts 3 cycles after the flush-low sample.
REQ-015 SHALL, in HDR0/HDR1, drive data = {1'b0, size} zero-extended, where size = latched cfg_size clamped to DEPTH.
REQ-016 SHALL, in PLD0/PLD1, drive data = {1'b0, bank[i]} for i = 0..size-1 in ascending order.
REQ-017 SHALL transfer a word only when valid && ready in the same cycle.
REQ-018 SHALL keep valid and data stable while valid && !ready, and SHALL never drop valid before the transfer.
REQ-019 SHALL sustain 1 word/cycle with ready held high, with no bubbles between header and payload or between blocks; the sync-read latency is hidden by a prefetch/skid register.
REQ-020 SHALL send a header only when size is 0 and then advance directly to the next block.
REQ-021 SHALL go from the last PLD0 transfer to HDR1 if cfg_num_blocks = 1, otherwise to DONE; from PLD1 it SHALL go to DONE.
REQ-022 SHALL in DONE hold valid = 0 and done = 1 (sticky); flush sampled 1 SHALL re-enter ARMED and clear done.
REQ-023 SHALL, on flush = 1 in GAP/HDR*/PLD*, abort: valid = 0 next cycle, go to ARMED, and discard the partial block.
REQ-024 SHALL accept fill writes only in IDLE, ARMED and DONE; writes in other states SHALL be ignored.
REQ-025 SHALL wrap the payload index only via the clamp (index never exceeds DEPTH-1).

Reset
REQ-026 SHALL on rst = 1 force: state IDLE, valid 0, data 0, done 0, counters 0, prefetch register empty.
REQ-027 SHALL let reset mid-transfer drop valid on the next edge regardless of ready; bank contents are not cleared.

Configuration
REQ-028 SHALL with GLB_WRITE_STALL_CNT_EN defined add output stall_cnt (32 bits): counts cycles with valid && !ready, cleared by rst and on entry to GAP, saturating at 2^32-1.
REQ-029 SHALL without GLB_WRITE_STALL_CNT_EN omit the port and its logic entirely.

Structure
REQ-030 SHALL place in package glb_write_pkg: the FSM state enum, the DEFAULT_DEPTH constant, the STREAM_W = 17 constant and the GAP_CYCLES = 3 constant.
REQ-031 SHALL instantiate sub-module glb_write_bank (1R1W memory, 16-bit, DEPTH words, synchronous 1-cycle read) twice, once per bank.

Verification
REQ-032 SHALL cover one block: fill bank0 with 0x0000..0x0004, size0 = 5, ready = 1, flush pulse -> valid 3 cycles after flush low; words 0x00005, 0x00000..0x00004 on consecutive cycles; done next cycle.
REQ-033 SHALL cover two blocks: size0 = 3, size1 = 2, bank1 = 0xBEEF,0xCAFE -> 0x00003, b0[0..2], 0x00002, 0x0BEEF, 0x0CAFE with no gaps; done = 1.
REQ-034 SHALL cover backpressure: random ready, 50% -> data stable while stalled, sequence identical to REQ-032, stall_cnt equals the stalled cycles (macro defined).
REQ-035 SHALL cover zero size: size0 = 0, two blocks, size1 = 1 -> 0x00000, 0x00001, b1[0]; no payload for block 0.
REQ-036 SHALL cover abort and reset: flush high during PLD0 word 2 -> valid 0 next cycle, re-flush restarts from header; rst during PLD1 -> valid 0, done 0, state IDLE.
REQ-037 SHALL cover clamp: cfg_size_0 = 4095 (width allowing) -> header 0x00800, exactly 2048 payload words.
